// File: rtl/std_fifo_push_arb_if.sv
// Push-side bundle between producers, the arbiter and a shared std_fifo.
// Carries the lock vector only when STD_FIFO_PUSH_ARB_LOCK_EN is defined.
interface std_fifo_push_arb_if #(
    parameter int N = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH_ADDR_WIDTH = 3
);
    logic [N-1:0]            req;
    logic [N*WIDTH-1:0]      req_d;
    logic [N-1:0]            gnt;
    logic                    fifo_push;
    logic [WIDTH-1:0]        fifo_d;
    logic [DEPTH_ADDR_WIDTH:0] fifo_count;
`ifdef STD_FIFO_PUSH_ARB_LOCK_EN
    logic [N-1:0]            lock;

    modport master (
        output req, req_d, fifo_count, lock,
        input  gnt, fifo_push, fifo_d
    );
    modport slave (
        input  req, req_d, fifo_count, lock,
        output gnt, fifo_push, fifo_d
    );
`else
    modport master (
        output req, req_d, fifo_count,
        input  gnt, fifo_push, fifo_d
    );
    modport slave (
        input  req, req_d, fifo_count,
        output gnt, fifo_push, fifo_d
    );
`endif
endinterface

// File: rtl/std_fifo_push_arb.sv
// Round-robin arbiter sharing the push side of one std_fifo among N producers.
// Optional burst locking is enabled with STD_FIFO_PUSH_ARB_LOCK_EN.
module std_fifo_push_arb #(
    parameter int N = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int DEPTH_ADDR_WIDTH = $clog2(DEPTH - 1)
) (
    input logic                clk,
    input logic                rst,
    std_fifo_push_arb_if.slave bus
);
    localparam int PW = $clog2(N);
    localparam int CW = DEPTH_ADDR_WIDTH + 2;

    logic [PW-1:0]    ptr;
    logic             push_r;
    logic [WIDTH-1:0] d_r;
    logic [CW-1:0]    occ;
    logic             space;
    logic [N-1:0]     elig;
    logic [N-1:0]     gnt_c;
    logic [PW-1:0]    win;
    logic             found;
    logic             xfer;
    int               idx;

    // The FIFO count lags the push in flight by one cycle, so add it back.
    assign occ   = CW'(bus.fifo_count) + CW'(push_r);
    assign space = occ < CW'(DEPTH);

`ifdef STD_FIFO_PUSH_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] owner, owner_nx;

    // While locked only the owner competes for the FIFO.
    always_comb begin
        elig = bus.req;
        if (state == LOCKED) elig = bus.req & (N'(1) << owner);
    end

    // Lock entry on a locked transfer, exit on unlock transfer or dropped req.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        unique case (state)
            UNLOCKED: begin
                if (xfer && bus.lock[win]) begin
                    state_nx = LOCKED;
                    owner_nx = win;
                end
            end
            LOCKED: begin
                if (!bus.req[owner] || (xfer && !bus.lock[owner]))
                    state_nx = UNLOCKED;
            end
            default: state_nx = UNLOCKED;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end
`else
    assign elig = bus.req;
`endif

    // Search from ptr upward, wrapping; first eligible request wins.
    always_comb begin
        gnt_c = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        if (found && space && rst) gnt_c[win] = 1'b1;
    end

    assign xfer          = |gnt_c;
    assign bus.gnt       = gnt_c;
    assign bus.fifo_push = push_r;
    assign bus.fifo_d    = d_r;

    // Capture the winner's word and advance the pointer past it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            push_r <= 1'b0;
            d_r    <= '0;
        end else begin
            push_r <= xfer;
            if (xfer) begin
                d_r <= bus.req_d[int'(win)*WIDTH +: WIDTH];
                ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_std_fifo_push_arb.sv
// Directed and randomized bench for std_fifo_push_arb.
// The FIFO occupancy is modelled in the bench and fed back as fifo_count.
module tb_std_fifo_push_arb;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int DAW   = $clog2(DEPTH - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;

    std_fifo_push_arb_if #(.N(N), .WIDTH(W), .DEPTH_ADDR_WIDTH(DAW)) bus ();

    std_fifo_push_arb #(
        .N(N), .WIDTH(W), .DEPTH(DEPTH), .DEPTH_ADDR_WIDTH(DAW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int         m_ptr   = 0;
    bit         m_push  = 0;
    logic [W-1:0] m_d   = '0;
    int         m_count = 0;
    int         ngrant  = 0;
    logic [N-1:0] obs_gnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int exp_winner(input logic [N-1:0] r);
        if (m_count + int'(m_push) >= DEPTH) return -1;
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic cyc(input logic [N-1:0] r, input bit pop);
        int w;
        bit pop_ok;
        bus.req = r;
        for (int i = 0; i < N; i++)
            bus.req_d[i*W +: W] = W'($urandom);
        bus.fifo_count = (DAW+1)'(m_count);
        #1;
        w = exp_winner(r);
        obs_gnt = bus.gnt;
        chk("gnt", 32'(bus.gnt), (w < 0) ? 0 : (1 << w));
        chk("fifo_push", 32'(bus.fifo_push), 32'(m_push));
        chk("fifo_d", 32'(bus.fifo_d), 32'(m_d));
        chk("overflow", 32'(bus.fifo_push && (m_count >= DEPTH)), 0);
        if (w >= 0) ngrant++;
        @(posedge clk);
        pop_ok  = pop && (m_count > 0);
        m_count = m_count + int'(m_push) - int'(pop_ok);
        if (w >= 0) begin
            m_d    = bus.req_d[w*W +: W];
            m_push = 1'b1;
            m_ptr  = (w + 1) % N;
        end else begin
            m_push = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req        = '1;
        bus.req_d      = '0;
        bus.fifo_count = '0;
`ifdef STD_FIFO_PUSH_ARB_LOCK_EN
        bus.lock       = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_push", 32'(bus.fifo_push), 0);
        chk("rst_d", 32'(bus.fifo_d), 0);

        rst = 1'b1;
        cyc(4'b1111, 1'b1);
        chk("first_gnt", 32'(obs_gnt), 32'h1);

        for (int i = 0; i < 11; i++) cyc(4'b1111, 1'b1);

        for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b1);
        chk("drained", 32'(m_count + int'(m_push)), 0);

        ngrant = 0;
        for (int i = 0; i < 12; i++) cyc(4'b0100, 1'b0);
        chk("throttle_cnt", 32'(ngrant), DEPTH);
        chk("full_gnt", 32'(bus.gnt), 0);

        ngrant = 0;
        cyc(4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b0);
        chk("one_more", 32'(ngrant), 1);

        for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b1);
        cyc(4'b0101, 1'b1);
        chk("wrap_gnt", 32'(obs_gnt), 32'h1);
        cyc(4'b0101, 1'b1);
        chk("skip_gnt", 32'(obs_gnt), 32'h4);

        for (int i = 0; i < 300; i++)
            cyc(N'($urandom), ($urandom_range(0, 3) != 0));

        for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b1);
        cyc(4'b1111, 1'b1);
        chk("burst_push", 32'(bus.fifo_push), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_push", 32'(bus.fifo_push), 0);
        chk("mid_rst_d", 32'(bus.fifo_d), 0);
        chk("mid_rst_gnt", 32'(bus.gnt), 0);
        m_ptr   = 0;
        m_push  = 1'b0;
        m_d     = '0;
        m_count = 0;
        @(negedge clk);
        rst = 1'b1;
        cyc(4'b1110, 1'b1);
        chk("post_rst_gnt", 32'(obs_gnt), 32'h2);
        cyc(4'b1111, 1'b1);
        chk("post_rst_next", 32'(obs_gnt), 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
